// File: rtl/mnist_nn_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the pulse-capable output PIO.
// Zero-wait-state bus: readdata is combinational from address.
interface mnist_nn_pio_out_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/mnist_nn_pio_out_pulse.sv
// Output PIO with atomic set/clear and hardware-timed auto-clearing pulses.
// Optional MNIST_NN_PIO_IRQ_EN adds a registered completion interrupt and STATUS.irq_en.
module mnist_nn_pio_out_pulse #(
  parameter int unsigned      WIDTH             = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
  parameter int unsigned      PULSE_CNT_W       = 16,
  parameter int unsigned      DEFAULT_PULSE_LEN = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  mnist_nn_pio_out_pulse_if.slave bus,
  output logic [WIDTH-1:0]        out_port
`ifdef MNIST_NN_PIO_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_LEN    = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0]       data_q;
  logic [WIDTH-1:0]       pulse_mask;
  logic [PULSE_CNT_W-1:0] cnt;
  logic [PULSE_CNT_W-1:0] pulse_len;
  logic [PULSE_CNT_W-1:0] eff_len;
  logic                   busy;
  logic                   done;
  logic                   wr;
  logic [WIDTH-1:0]       mask;
  logic                   pulse_start;
  logic                   pulse_end;
  logic [31:0]            rdata;
  logic                   unused_wd;

  assign wr          = bus.chipselect & ~bus.write_n;
  assign mask        = bus.writedata[WIDTH-1:0];
  assign unused_wd   = ^bus.writedata;
  assign eff_len     = (pulse_len == '0) ? PULSE_CNT_W'(1) : pulse_len;
  assign pulse_start = wr && (bus.address == ADDR_PULSE) && (mask != '0);
  // A retrigger in the final cycle reloads the counter instead of completing.
  assign pulse_end   = !pulse_start && busy && (cnt == PULSE_CNT_W'(1));

  assign out_port = data_q | pulse_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VALUE;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:  data_q <= mask;
        ADDR_SET:   data_q <= data_q | mask;
        ADDR_CLEAR: data_q <= data_q & ~mask;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_mask <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
    end else if (pulse_start) begin
      pulse_mask <= pulse_mask | mask;
      cnt        <= eff_len;
      busy       <= 1'b1;
    end else if (busy) begin
      if (cnt == PULSE_CNT_W'(1)) begin
        pulse_mask <= '0;
        cnt        <= '0;
        busy       <= 1'b0;
      end else begin
        cnt <= cnt - PULSE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_len <= PULSE_CNT_W'(DEFAULT_PULSE_LEN);
    end else if (wr && (bus.address == ADDR_LEN)) begin
      pulse_len <= bus.writedata[PULSE_CNT_W-1:0];
    end
  end

  // Completion has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else if (pulse_end) begin
      done <= 1'b1;
    end else if (wr && (bus.address == ADDR_STATUS) && bus.writedata[1]) begin
      done <= 1'b0;
    end
  end

`ifdef MNIST_NN_PIO_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && (bus.address == ADDR_STATUS)) begin
        irq_en <= bus.writedata[2];
      end
      irq <= done & irq_en;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:  rdata = 32'(data_q);
      ADDR_PULSE: rdata = 32'(pulse_mask);
      ADDR_LEN:   rdata = 32'(pulse_len);
      ADDR_STATUS: begin
        rdata[0] = busy;
        rdata[1] = done;
`ifdef MNIST_NN_PIO_IRQ_EN
        rdata[2] = irq_en;
`endif
      end
      default:    rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;

endmodule
